// File: rtl/bcd_code_converter.sv
// ---------------------------------------------------------------------------------------------
// bcd_code_converter
//
// Converts a DIGITS-digit BCD word into one of four weighted/unweighted decimal codes.
// The conversion is serial: after a word is accepted it converts one digit per clock,
// starting with digit 0. The result is then held until the consumer takes it.
//
// Optional feature (compile-time macro BCD_CONV_ERR_EN):
//   defined   - a digit greater than 9 gives a 0000 output nibble and sets out_err for the word.
//   undefined - out_err is tied to 0, and a digit greater than 9 passes through unchanged.
//
// Parameters:
//   DIGITS     number of BCD digits per word (1..8)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_mode valid
//   in_ready   block can accept a word (IDLE only)
//   in_data    BCD word, digit 0 in bits [3:0]
//   in_mode    00 = 8421, 01 = 2421, 10 = excess-3, 11 = 5421
//   out_valid  out_data/out_err valid (DONE only)
//   out_ready  consumer takes the result
//   out_data   converted word, same digit order as in_data
//   out_err    some input digit was greater than 9
// ---------------------------------------------------------------------------------------------
module bcd_code_converter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err
);

    localparam int unsigned    IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StConv = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [IdxW-1:0]       r_idx;
    logic [IdxW-1:0]       w_idx_next;
    logic [1:0]            r_mode;
    logic [1:0]            w_mode_next;
    logic [4*DIGITS-1:0]   r_data;
    logic [4*DIGITS-1:0]   w_data_next;
    logic [4*DIGITS-1:0]   r_out_data;
    logic [4*DIGITS-1:0]   w_out_data_next;
    logic [3:0]            w_digit;
    logic [3:0]            w_conv;

    // Code conversion for a single digit. Out-of-range digits pass through here; the
    // error build overrides them below.
    function automatic logic [3:0] conv_digit(input logic [3:0] d, input logic [1:0] mode);
        logic [3:0] nib;
        nib = d;
        if (d <= 4'd9) begin
            case (mode)
                2'b00:   nib = d;
                2'b01:   nib = (d < 4'd5) ? d : d + 4'd6;  // 5..9 -> 1011..1111
                2'b10:   nib = d + 4'd3;
                default: nib = (d < 4'd5) ? d : d + 4'd3;  // 5..9 -> 1000..1100
            endcase
        end
        return nib;
    endfunction

    // Select the digit addressed by the current index.
    always_comb begin
        w_digit = 4'd0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_idx == IdxW'(d)) begin
                w_digit = r_data[4*d +: 4];
            end
        end
    end

`ifdef BCD_CONV_ERR_EN
    logic w_digit_bad;
    logic r_err;
    logic w_err_next;

    assign w_digit_bad = (w_digit > 4'd9);
    assign w_conv      = w_digit_bad ? 4'd0 : conv_digit(w_digit, r_mode);
`else
    assign w_conv      = conv_digit(w_digit, r_mode);
`endif

    // Next-state and datapath control.
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_mode_next     = r_mode;
        w_data_next     = r_data;
        w_out_data_next = r_out_data;
`ifdef BCD_CONV_ERR_EN
        w_err_next      = r_err;
`endif
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_next    = StConv;
                    w_idx_next      = '0;
                    w_mode_next     = in_mode;
                    w_data_next     = in_data;
                    w_out_data_next = '0;
`ifdef BCD_CONV_ERR_EN
                    w_err_next      = 1'b0;
`endif
                end
            end
            StConv: begin
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    if (r_idx == IdxW'(d)) begin
                        w_out_data_next[4*d +: 4] = w_conv;
                    end
                end
`ifdef BCD_CONV_ERR_EN
                w_err_next = r_err | w_digit_bad;
`endif
                if (r_idx == LastIdx) begin
                    w_state_next = StDone;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_mode     <= 2'b00;
            r_data     <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_mode     <= w_mode_next;
            r_data     <= w_data_next;
            r_out_data <= w_out_data_next;
        end
    end

`ifdef BCD_CONV_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_bcd_code_converter.sv
// ---------------------------------------------------------------------------------------------
// tb_bcd_code_converter
//
// Directed self-checking bench for bcd_code_converter with DIGITS = 4. Expected values are
// hand-computed; the invalid-digit vectors follow BCD_CONV_ERR_EN as defined for this build.
// ---------------------------------------------------------------------------------------------
module tb_bcd_code_converter;

    localparam int unsigned DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    bcd_code_converter #(
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one word, scramble the inputs while it converts, check latency and result,
    // then release it. With hold_ready the consumer is ready before the result exists.
    task automatic run_word(input string tag, input logic [15:0] din, input logic [1:0] mode,
                            input logic [15:0] exp_data, input logic exp_err,
                            input bit hold_ready);
        int cyc;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = din;
        in_mode   = mode;
        out_ready = hold_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_data  = ~din;
        chk({tag, "_in_ready_conv"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(DIGITS));
        chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        if (!hold_ready) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin : stim
        logic [15:0] held_data;
        logic        held_err;
        int          cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready held high from the start must not disturb the conversion.
        run_word("m01_1959", 16'h1959, 2'b01, 16'h1FBF, 1'b0, 1'b1);
        run_word("m10_0429", 16'h0429, 2'b10, 16'h375C, 1'b0, 1'b0);
        run_word("m11_9876", 16'h9876, 2'b11, 16'hCBA9, 1'b0, 1'b0);
        run_word("m00_1234", 16'h1234, 2'b00, 16'h1234, 1'b0, 1'b0);
        run_word("m10_0000", 16'h0000, 2'b10, 16'h3333, 1'b0, 1'b0);
        run_word("m11_9999", 16'h9999, 2'b11, 16'hCCCC, 1'b0, 1'b0);
        run_word("m01_5678", 16'h5678, 2'b01, 16'hBCDE, 1'b0, 1'b0);
`ifdef BCD_CONV_ERR_EN
        run_word("m01_12A4", 16'h12A4, 2'b01, 16'h1204, 1'b1, 1'b0);
        run_word("m10_00F0", 16'h00F0, 2'b10, 16'h3303, 1'b1, 1'b0);
`else
        run_word("m01_12A4", 16'h12A4, 2'b01, 16'h12A4, 1'b0, 1'b0);
        run_word("m10_00F0", 16'h00F0, 2'b10, 16'h33F3, 1'b0, 1'b0);
`endif
        // Error flag must not leak into the next clean word.
        run_word("m00_after_err", 16'h0908, 2'b00, 16'h0908, 1'b0, 1'b0);

        // Stall in DONE for 5 cycles while the producer keeps pushing.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h2468;
        in_mode  = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stall_latency", 32'(cyc), 32'd4);
        chk("stall_data", 32'(out_data), 32'h579B);
        held_data = out_data;
        held_err  = out_err;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = in_data + 16'h1111;
            in_mode  = in_mode + 2'b01;
            @(posedge clk);
            #1;
            chk("stall_hold", {13'd0, out_valid, in_ready, out_err, out_data},
                {13'd0, 1'b1, 1'b0, held_err, held_data});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_release", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset pulse while converting digit 2.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        in_mode  = 2'b01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async", {30'd0, out_valid, in_ready}, 32'b01);
        chk("abort_data", 32'(out_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) cyc++;
        end
        chk("abort_no_output", 32'(cyc), 32'd0);
        run_word("after_reset_0005", 16'h0005, 2'b01, 16'h000B, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
